// File: rtl/au_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter and its one-hot encoder:
// the index-width helper and the two-state grant FSM encoding.
package au_rr_arbiter_pkg;

    // Bits needed to index x items, never less than one.
    function automatic int clogb2(input int x);
        int r;
        r = 1;
        while ((1 << r) < x) r++;
        return r;
    endfunction

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_t;

endpackage

// File: rtl/au_rr_arbiter_encode.sv
// One-hot to binary encoder; the input must carry at most one set bit,
// and an all-zero input encodes to index 0.
module AU_encode
    import au_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = clogb2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    output logic [IW-1:0]    z
);

    always_comb begin
        z = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) z = z | IW'(i);
        end
    end

endmodule

// File: rtl/au_rr_arbiter.sv
// Registered round-robin arbiter with a valid/ready grant handshake; the
// just-served requester is masked for the cycle of its handshake.
module au_rr_arbiter
    import au_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = clogb2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    state_t           state_p0, state_n;
    logic [IW-1:0]    ptr_p0, ptr_n, ptr_inc;
    logic [WIDTH-1:0] gnt_p0, gnt_n;

    // Rotate the doubled vector so bit p lands at 0, isolate the lowest set
    // bit, then rotate the result back into requester positions.
    function automatic logic [WIDTH-1:0] rr_pick(input logic [WIDTH-1:0] cand,
                                                 input logic [IW-1:0]    p);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   rot;
        logic [WIDTH-1:0]   low;
        logic [2*WIDTH-1:0] back;
        dbl  = {cand, cand};
        rot  = dbl[p +: WIDTH];
        low  = rot & (~rot + WIDTH'(1));
        back = {low, low} << p;
        return back[WIDTH +: WIDTH];
    endfunction

    assign ptr_inc = (gnt_idx == IW'(WIDTH - 1)) ? '0 : gnt_idx + IW'(1);

    always_comb begin
        state_n = state_p0;
        ptr_n   = ptr_p0;
        gnt_n   = gnt_p0;
        case (state_p0)
            IDLE: begin
                if (|req) begin
                    gnt_n   = rr_pick(req, ptr_p0);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    ptr_n   = ptr_inc;
                    gnt_n   = rr_pick(req & ~gnt_p0, ptr_inc);
                    state_n = (|gnt_n) ? GRANT : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // Stage p0: FSM state, priority pointer and registered grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            ptr_p0   <= '0;
            gnt_p0   <= '0;
        end else begin
            state_p0 <= state_n;
            ptr_p0   <= ptr_n;
            gnt_p0   <= gnt_n;
        end
    end

    assign gnt_valid = (state_p0 == GRANT);
    assign gnt       = gnt_p0;

    AU_encode #(.WIDTH(WIDTH)) u_encode (
        .a (gnt_p0),
        .z (gnt_idx)
    );

endmodule

// File: tb/tb_au_rr_arbiter.sv
// Bench for au_rr_arbiter (WIDTH=8): a directed cycle table, a held-grant
// sequence, and randomized traffic against a search-based reference model.
module tb_au_rr_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic         gnt_valid;
    logic         gnt_ready;
    logic [W-1:0] gnt;
    logic [2:0]   gnt_idx;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: valid flag, granted index and priority pointer.
    int m_valid = 0;
    int m_idx   = 0;
    int m_ptr   = 0;

    typedef struct {
        logic         rst;
        logic [W-1:0] req;
        logic         rdy;
        logic         vld;
        logic [W-1:0] gnt;
        logic [2:0]   idx;
    } vec_t;

    vec_t vecs[$];

    au_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic r, input logic [W-1:0] q, input logic y,
                                input logic v, input logic [W-1:0] g, input logic [2:0] i);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = y; t.vld = v; t.gnt = g; t.idx = i;
        vecs.push_back(t);
    endfunction

    // Scan from the start position, wrapping, for the first requesting bit
    // other than the excluded one; -1 when none.
    function automatic int search(input logic [W-1:0] r, input int start, input int excl);
        for (int k = 0; k < W; k++) begin
            int j;
            j = (start + k) % W;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [W-1:0] q, input logic y);
        int w;
        if (r) begin
            m_valid = 0; m_idx = 0; m_ptr = 0;
        end else if (m_valid == 0) begin
            w = search(q, m_ptr, -1);
            if (w >= 0) begin m_valid = 1; m_idx = w; end
        end else if (y) begin
            m_ptr = (m_idx + 1) % W;
            w = search(q, m_ptr, m_idx);
            if (w >= 0) m_idx = w;
            else begin m_valid = 0; m_idx = 0; end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; gnt_ready = 1'b0;

        // Reset with all requesting, then release
        for (int i = 0; i < 3; i++) add(1, 8'hFF, 0, 0, 8'h00, 0);
        add(0, 8'hFF, 1, 1, 8'h01, 0);
        // Full rotation and wrap to requester 0
        for (int i = 1; i < 8; i++) add(0, 8'hFF, 1, 1, 8'(1 << i), 3'(i));
        add(0, 8'hFF, 1, 1, 8'h01, 0);
        // Drain to idle, pointer now 1
        add(0, 8'h00, 1, 0, 8'h00, 0);
        // Backpressure, grant held even with req[2] dropped
        add(0, 8'h24, 0, 1, 8'h04, 2);
        add(0, 8'h20, 0, 1, 8'h04, 2);
        add(0, 8'h24, 0, 1, 8'h04, 2);
        add(0, 8'h24, 1, 1, 8'h20, 5);
        // Wrap-around from index 6 to 7 to 0
        add(0, 8'h40, 1, 1, 8'h40, 6);
        add(0, 8'h81, 1, 1, 8'h80, 7);
        add(0, 8'h81, 1, 1, 8'h01, 0);
        // Sole requester alternates
        add(0, 8'h08, 1, 1, 8'h08, 3);
        add(0, 8'h08, 1, 0, 8'h00, 0);
        add(0, 8'h08, 1, 1, 8'h08, 3);
        add(0, 8'h08, 1, 0, 8'h00, 0);
        add(0, 8'h08, 1, 1, 8'h08, 3);
        // Reset during a handshake, pointer restarts at 0
        add(0, 8'h10, 1, 1, 8'h10, 4);
        add(1, 8'hFF, 1, 0, 8'h00, 0);
        add(0, 8'hFF, 1, 1, 8'h01, 0);

        foreach (vecs[n]) begin
            rst = vecs[n].rst; req = vecs[n].req; gnt_ready = vecs[n].rdy;
            tick();
            chk($sformatf("vec%0d.valid", n), int'(gnt_valid), int'(vecs[n].vld));
            chk($sformatf("vec%0d.gnt", n),   int'(gnt),       int'(vecs[n].gnt));
            chk($sformatf("vec%0d.idx", n),   int'(gnt_idx),   int'(vecs[n].idx));
        end

        // Held grant survives all requests vanishing, then drops on handshake
        rst = 1'b0; req = 8'h00; gnt_ready = 1'b1;
        tick();
        req = 8'h02; gnt_ready = 1'b0;
        tick();
        chk("hold.first", int'(gnt), 8'h02);
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold.gnt%0d", i), int'(gnt), 8'h02);
            chk($sformatf("hold.valid%0d", i), int'(gnt_valid), 1);
        end
        gnt_ready = 1'b1;
        tick();
        chk("hold.release_valid", int'(gnt_valid), 0);
        chk("hold.release_gnt", int'(gnt), 0);

        // Randomized traffic against the reference model
        rst = 1'b1; req = '0; gnt_ready = 1'b0;
        tick();
        model_step(1'b1, '0, 1'b0);
        for (int c = 0; c < 2000; c++) begin
            logic [W-1:0] r;
            logic         nr;
            r = W'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & W'($urandom);
            req       = r;
            gnt_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            nr        = rst;
            tick();
            model_step(nr, req, gnt_ready);
            chk($sformatf("rand%0d.valid", c), int'(gnt_valid), m_valid);
            chk($sformatf("rand%0d.gnt", c), int'(gnt), m_valid ? (1 << m_idx) : 0);
            chk($sformatf("rand%0d.idx", c), int'(gnt_idx), m_valid ? m_idx : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
